// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: serialises 16-bit stereo pairs from a one-deep holding buffer into an I2S stream.
// Build option: define AUDIO_I2S_TX_UNDERRUN_MUTE_EN to send a silent frame on underrun instead of repeating the last pair.
module audio_i2s_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SLOT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned IDX_W    = $clog2(SAMPLE_W);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] LR_FIRST  = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] LR_LAST   = BIT_W'(2 * SLOT_W - 2);
    localparam logic [BIT_W-1:0] R_BASE    = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] MSB_POS   = BIT_W'(SAMPLE_W - 1);
    localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(SAMPLE_W);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                sdata_q, sdata_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic                in_ready_q, in_ready_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;

    logic                div_wrap, fall_edge, boundary, accept;
    logic [BIT_W-1:0]    bit_nxt, r_rel;

    // Divider, handshake, frame load and next serial bit
    always_comb begin
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        bclk_d        = bclk_q;
        lrck_d        = lrck_q;
        sdata_d       = sdata_q;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        frm_l_d       = frm_l_q;
        frm_r_d       = frm_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        div_wrap  = (div_cnt_q == DIV_LAST);
        fall_edge = div_wrap && bclk_q;
        bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        boundary  = fall_edge && (bit_nxt == '0);
        accept    = in_valid && in_ready_q;
        r_rel     = bit_nxt - R_BASE;

        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        if (div_wrap) begin
            bclk_d = ~bclk_q;
        end

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = in_l;
            buf_r_d    = in_r;
        end

        // A coincident accept on an empty buffer is held for the following frame.
        if (boundary) begin
            frame_start_d = 1'b1;
            if (buf_full_q) begin
                frm_l_d    = buf_l_q;
                frm_r_d    = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
`ifdef AUDIO_I2S_TX_UNDERRUN_MUTE_EN
                frm_l_d    = '0;
                frm_r_d    = '0;
`endif
            end
        end

        if (fall_edge) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = (bit_nxt >= LR_FIRST) && (bit_nxt <= LR_LAST);
            if (bit_nxt < DATA_BITS) begin
                sdata_d = frm_l_d[IDX_W'(MSB_POS - bit_nxt)];
            end else if ((bit_nxt >= R_BASE) && (r_rel < DATA_BITS)) begin
                sdata_d = frm_r_d[IDX_W'(MSB_POS - r_rel)];
            end else begin
                sdata_d = 1'b0;
            end
        end

        in_ready_d = ~buf_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= BIT_LAST;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            frm_l_q       <= '0;
            frm_r_q       <= '0;
            in_ready_q    <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= bclk_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            frm_l_q       <= frm_l_d;
            frm_r_q       <= frm_r_d;
            in_ready_q    <= in_ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign i2s_bclk    = bclk_q;
    assign i2s_lrck    = lrck_q;
    assign i2s_sdata   = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench; expected frames are queued by the stimulus and a monitor deserialises and compares them.
module tb_audio_i2s_tx;

    typedef struct {
        logic [63:0] data;
        logic        und;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_l0, in_r0, in_l1, in_r1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, bclk0, lrck0, sdata0, fs0, und0;
    logic        in_ready1, bclk1, lrck1, sdata1, fs1, und1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        mon_act  [2] = '{1'b0, 1'b0};
    logic        mon_prev [2] = '{1'b0, 1'b0};
    logic        mon_und  [2] = '{1'b0, 1'b0};
    int          mon_nb   [2] = '{0, 0};
    int          mon_cyc  [2] = '{0, 0};
    int          mon_last [2] = '{-1, -1};
    logic [63:0] mon_sh   [2] = '{64'd0, 64'd0};
    logic [63:0] mon_lr   [2] = '{64'd0, 64'd0};

    always #5 clk = ~clk;

    audio_i2s_tx #(.CLK_DIV(2), .SLOT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_l(in_l0), .in_r(in_r0), .in_valid(in_valid0),
        .in_ready(in_ready0), .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_sdata(sdata0),
        .frame_start(fs0), .underrun(und0)
    );

    audio_i2s_tx #(.CLK_DIV(1), .SLOT_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_l(in_l1), .in_r(in_r1), .in_valid(in_valid1),
        .in_ready(in_ready1), .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1),
        .frame_start(fs1), .underrun(und1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [63:0] d, input logic u);
        exp_t e;
        e.data = d;
        e.und  = u;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Deserialise one frame per frame_start, sampling sdata/lrck on each BCLK rising edge.
    task automatic mon(input int k, input logic fs, input logic und, input logic bclk,
                       input logic lrck, input logic sdata);
        int          s;
        logic        have;
        exp_t        e;
        logic [63:0] lr_exp;
        s = (k == 0) ? 16 : 32;
        mon_cyc[k]++;
        if (!reset_n) begin
            mon_act[k]  = 1'b0;
            mon_last[k] = -1;
        end else begin
            if (und) chk($sformatf("underrun_without_fs%0d", k), 64'(fs), 64'd1);
            if (fs) begin
                if (mon_last[k] >= 0)
                    chk($sformatf("frame_period%0d", k), 64'(mon_cyc[k] - mon_last[k]), 64'd128);
                mon_last[k] = mon_cyc[k];
                mon_act[k]  = 1'b1;
                mon_nb[k]   = 0;
                mon_sh[k]   = '0;
                mon_lr[k]   = '0;
                mon_und[k]  = und;
            end else if (mon_act[k] && bclk && !mon_prev[k]) begin
                mon_sh[k] = {mon_sh[k][62:0], sdata};
                mon_lr[k][mon_nb[k]] = lrck;
                mon_nb[k]++;
                if (mon_nb[k] == 2 * s) begin
                    mon_act[k] = 1'b0;
                    lr_exp = '0;
                    for (int i = s - 1; i <= 2 * s - 2; i++) lr_exp[i] = 1'b1;
                    have = 1'b0;
                    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (have) begin
                        chk($sformatf("frame_data%0d", k), mon_sh[k], e.data);
                        chk($sformatf("frame_underrun%0d", k), 64'(mon_und[k]), 64'(e.und));
                        chk($sformatf("frame_lrck%0d", k), mon_lr[k], lr_exp);
                    end
                end
            end
        end
        mon_prev[k] = bclk;
    endtask

    always @(negedge clk) begin
        mon(0, fs0, und0, bclk0, lrck0, sdata0);
        mon(1, fs1, und1, bclk1, lrck1, sdata1);
    end

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs0 && n < 200);
        chk($sformatf("%s_seen", name), 64'(fs0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic [63:0] rep_a, rep_b, rep_1;
`ifdef AUDIO_I2S_TX_UNDERRUN_MUTE_EN
        rep_a = 64'h0;
        rep_b = 64'h0;
        rep_1 = 64'h0;
`else
        rep_a = 64'h0000_0000_A5C3_8001;
        rep_b = 64'h0000_0000_7FFF_FFFF;
        rep_1 = 64'hA5C3_0000_8001_0000;
`endif
        reset_n   = 1'b0;
        in_valid0 = 1'b0; in_l0 = '0; in_r0 = '0;
        in_valid1 = 1'b0; in_l1 = '0; in_r1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_bclk", 64'(bclk0), 64'd0);
        chk("rst_lrck", 64'(lrck0), 64'd0);
        chk("rst_sdata", 64'(sdata0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        chk("rst_frame_start", 64'(fs0), 64'd0);
        chk("rst_underrun", 64'(und0), 64'd0);
        chk("rst_in_ready1", 64'(in_ready1), 64'd1);

        push(0, 64'h0000_0000_A5C3_8001, 1'b0);  // F0
        push(0, rep_a, 1'b1);                    // F1
        push(0, rep_a, 1'b1);                    // F2
        push(0, rep_a, 1'b1);                    // F3
        push(0, 64'h0000_0000_1234_4321, 1'b0);  // F4
        push(0, 64'h0000_0000_7FFF_FFFF, 1'b0);  // F5
        push(0, rep_b, 1'b1);                    // F6
        push(0, rep_b, 1'b1);                    // F7 (coincident accept)
        push(0, 64'h0000_0000_3C5A_C3A5, 1'b0);  // F8
        push(1, 64'hA5C3_0000_8001_0000, 1'b0);
        push(1, rep_1, 1'b1);

        reset_n   = 1'b1;
        in_valid0 = 1'b1; in_l0 = 16'hA5C3; in_r0 = 16'h8001;
        in_valid1 = 1'b1; in_l1 = 16'hA5C3; in_r1 = 16'h8001;
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        chk("in_ready_after_accept", 64'(in_ready0), 64'd0);
        n = 1;
        while (!fs0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_frame_latency", 64'(n), 64'd4);

        wait_fs("f1");
        wait_fs("f2");
        wait_fs("f3");

        // Backpressure: second pair waits for the buffer to drain at the next boundary.
        repeat (40) @(negedge clk);
        in_valid0 = 1'b1; in_l0 = 16'h1234; in_r0 = 16'h4321;
        @(negedge clk);
        in_l0 = 16'h7FFF; in_r0 = 16'hFFFF;
        chk("in_ready_busy", 64'(in_ready0), 64'd0);
        n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (!fs0 && in_ready0) bad++;
        end while (!fs0 && n < 200);
        chk("in_ready_held_low", 64'(bad), 64'd0);
        chk("f4_seen", 64'(fs0), 64'd1);
        chk("in_ready_at_f4", 64'(in_ready0), 64'd1);
        @(negedge clk);
        in_valid0 = 1'b0;
        chk("in_ready_after_second", 64'(in_ready0), 64'd0);

        wait_fs("f5");
        wait_fs("f6");

        // Accept lands exactly on the F7 boundary edge, 128 clk after F6's.
        repeat (127) @(posedge clk);
        #1;
        in_valid0 = 1'b1; in_l0 = 16'h3C5A; in_r0 = 16'hC3A5;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("coincident_fs", 64'(fs0), 64'd1);
        chk("coincident_underrun", 64'(und0), 64'd1);
        chk("coincident_buffered", 64'(in_ready0), 64'd0);

        wait_fs("f8");
        wait_fs("f9");

        // Buffer a pair, then reset at bit_cnt 20 while BCLK and LRCK are high.
        in_valid0 = 1'b1; in_l0 = 16'hDEAD; in_r0 = 16'hBEEF;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        repeat (81) @(posedge clk);
        #1;
        chk("pre_rst_bclk", 64'(bclk0), 64'd1);
        chk("pre_rst_lrck", 64'(lrck0), 64'd1);
        chk("pre_rst_in_ready", 64'(in_ready0), 64'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bclk", 64'(bclk0), 64'd0);
        chk("async_rst_lrck", 64'(lrck0), 64'd0);
        chk("async_rst_sdata", 64'(sdata0), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready0), 64'd1);

        push(0, 64'h0, 1'b1);  // F10: buffered pair discarded, frame register cleared
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs0 && n < 20);
        chk("restart_latency", 64'(n), 64'd4);
        chk("restart_underrun", 64'(und0), 64'd1);

        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
